// File: rtl/rv_wb_pkg.sv
// rv_wb_pkg: shared types and constants for the register-file writeback arbiter
package rv_wb_pkg;
    typedef enum logic {NORMAL, FORCE_B} arb_state_t;
    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_A    = 2'd1;
    localparam logic [1:0] GNT_B    = 2'd2;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/wb_hold_buffer.sv
// wb_hold_buffer: single-entry valid/ready holding buffer for long-latency writeback results
// in_ready stays low for one extra cycle after the entry drains, so it is a pure register.
module wb_hold_buffer #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_reg,
    input  logic [DATA_W-1:0] in_data,
    input  logic              take,
    output logic              out_valid,
    output logic [REG_AW-1:0] out_reg,
    output logic [DATA_W-1:0] out_data
);
    logic load;

    assign load = in_valid && in_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_reg   <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= load || (out_valid && !take);
            in_ready  <= !(load || out_valid);
            if (load) begin
                out_reg  <= in_reg;
                out_data <= in_data;
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between pipeline (A) and long-latency (B) writeback
// Optional saturating statistics ports under REGFILE_WB_ARB_STATS_EN.
module regfile_wb_arbiter
    import rv_wb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              A_VALID,
    output logic              A_READY,
    input  logic [REG_AW-1:0] A_REG,
    input  logic [DATA_W-1:0] A_DATA,
    input  logic              B_VALID,
    output logic              B_READY,
    input  logic [REG_AW-1:0] B_REG,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              RF_WRITE_ENABLE,
    output logic [REG_AW-1:0] RF_WRITE_REG,
    output logic [DATA_W-1:0] RF_WRITE_DATA,
    output logic              B_PENDING,
    output logic [REG_AW-1:0] B_PENDING_REG
`ifdef REGFILE_WB_ARB_STATS_EN
    ,
    output logic [31:0]       A_WRITES,
    output logic [31:0]       B_WRITES,
    output logic [15:0]       FORCE_CNT
`endif
);
    arb_state_t        state, state_nx;
    logic [1:0]        grant;
    logic [3:0]        wait_cnt;
    logic              buf_valid, force_hit, wr;
    logic [REG_AW-1:0] buf_reg, g_reg;
    logic [DATA_W-1:0] buf_data, g_data;

    wb_hold_buffer #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_buf (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (B_VALID),
        .in_ready (B_READY),
        .in_reg   (B_REG),
        .in_data  (B_DATA),
        .take     (grant == GNT_B),
        .out_valid(buf_valid),
        .out_reg  (buf_reg),
        .out_data (buf_data)
    );

    assign A_READY       = state == NORMAL;
    assign B_PENDING     = buf_valid;
    assign B_PENDING_REG = buf_valid ? buf_reg : '0;

    always_comb begin
        grant     = state == FORCE_B ? GNT_B : A_VALID ? GNT_A : buf_valid ? GNT_B : GNT_NONE;
        g_reg     = grant == GNT_B ? buf_reg : A_REG;
        g_data    = grant == GNT_B ? buf_data : A_DATA;
        wr        = grant != GNT_NONE && g_reg != REG_AW'(REG_ZERO);
        force_hit = buf_valid && grant == GNT_A && wait_cnt == 4'(MAX_WAIT - 1);
        state_nx  = force_hit ? FORCE_B : NORMAL;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= NORMAL;
            wait_cnt        <= '0;
            RF_WRITE_ENABLE <= 1'b0;
            RF_WRITE_REG    <= '0;
            RF_WRITE_DATA   <= '0;
        end else begin
            state           <= state_nx;
            wait_cnt        <= grant == GNT_B ? 4'd0 : (buf_valid && grant == GNT_A) ? wait_cnt + 4'd1 : wait_cnt;
            RF_WRITE_ENABLE <= wr;
            if (wr) begin
                RF_WRITE_REG  <= g_reg;
                RF_WRITE_DATA <= g_data;
            end
        end
    end

`ifdef REGFILE_WB_ARB_STATS_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            A_WRITES  <= '0;
            B_WRITES  <= '0;
            FORCE_CNT <= '0;
        end else begin
            A_WRITES  <= (grant == GNT_A && A_WRITES != '1) ? A_WRITES + 32'd1 : A_WRITES;
            B_WRITES  <= (grant == GNT_B && B_WRITES != '1) ? B_WRITES + 32'd1 : B_WRITES;
            FORCE_CNT <= (force_hit && FORCE_CNT != '1) ? FORCE_CNT + 16'd1 : FORCE_CNT;
        end
    end
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vector table plus hand-written starvation/reset sequences
module tb_regfile_wb_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        A_VALID, B_VALID;
    logic        A_READY, B_READY;
    logic [4:0]  A_REG, B_REG;
    logic [31:0] A_DATA, B_DATA;
    logic        RF_WRITE_ENABLE, B_PENDING;
    logic [4:0]  RF_WRITE_REG, B_PENDING_REG;
    logic [31:0] RF_WRITE_DATA;
`ifdef REGFILE_WB_ARB_STATS_EN
    logic [31:0] A_WRITES, B_WRITES;
    logic [15:0] FORCE_CNT;
`endif
    int n_chk = 0;
    int n_fail = 0;

    regfile_wb_arbiter #(.MAX_WAIT(4), .DATA_W(32), .REG_AW(5)) dut (
        .CLK(CLK), .RST(RST),
        .A_VALID(A_VALID), .A_READY(A_READY), .A_REG(A_REG), .A_DATA(A_DATA),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_REG(B_REG), .B_DATA(B_DATA),
        .RF_WRITE_ENABLE(RF_WRITE_ENABLE), .RF_WRITE_REG(RF_WRITE_REG), .RF_WRITE_DATA(RF_WRITE_DATA),
        .B_PENDING(B_PENDING), .B_PENDING_REG(B_PENDING_REG)
`ifdef REGFILE_WB_ARB_STATS_EN
        , .A_WRITES(A_WRITES), .B_WRITES(B_WRITES), .FORCE_CNT(FORCE_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  br;
        logic [31:0] bd;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        a_rdy;
        logic        b_rdy;
        logic        pend;
        logic [4:0]  preg;
    } vec_t;

    vec_t vec [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd);
        A_VALID = av; A_REG = ar; A_DATA = ad;
        B_VALID = bv; B_REG = br; B_DATA = bd;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, " we"}, 32'(RF_WRITE_ENABLE), 32'd0);
        chk({nm, " pend"}, 32'(B_PENDING), 32'd0);
        chk({nm, " a_rdy"}, 32'(A_READY), 32'd1);
        chk({nm, " b_rdy"}, 32'(B_READY), 32'd1);
    endtask

    initial begin
        //          av ar  ad            bv br  bd            we wreg wdata        ar br pend preg
        vec[0]  = '{1, 5,  32'hDEADBEEF, 0, 0,  0,            1, 5,  32'hDEADBEEF, 1, 1, 0, 0};
        vec[1]  = '{0, 0,  0,            0, 0,  0,            0, 5,  32'hDEADBEEF, 1, 1, 0, 0};
        vec[2]  = '{0, 0,  0,            1, 7,  32'h12345678, 0, 5,  32'hDEADBEEF, 1, 0, 1, 7};
        vec[3]  = '{0, 0,  0,            0, 0,  0,            1, 7,  32'h12345678, 1, 0, 0, 0};
        vec[4]  = '{0, 0,  0,            0, 0,  0,            0, 7,  32'h12345678, 1, 1, 0, 0};
        vec[5]  = '{1, 0,  32'hFFFFFFFF, 0, 0,  0,            0, 7,  32'h12345678, 1, 1, 0, 0};
        vec[6]  = '{0, 0,  0,            1, 0,  32'hAAAA5555, 0, 7,  32'h12345678, 1, 0, 1, 0};
        vec[7]  = '{0, 0,  0,            0, 0,  0,            0, 7,  32'h12345678, 1, 0, 0, 0};
        vec[8]  = '{0, 0,  0,            0, 0,  0,            0, 7,  32'h12345678, 1, 1, 0, 0};
        vec[9]  = '{1, 3,  32'h33,       1, 4,  32'h44,       1, 3,  32'h33,       1, 0, 1, 4};
        vec[10] = '{0, 0,  0,            0, 0,  0,            1, 4,  32'h44,       1, 0, 0, 0};
        vec[11] = '{0, 0,  0,            0, 0,  0,            0, 4,  32'h44,       1, 1, 0, 0};

        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk_idle("reset");
        chk("reset wreg", 32'(RF_WRITE_REG), 32'd0);
        chk("reset wdata", RF_WRITE_DATA, 32'd0);
        RST = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vec[i].av, vec[i].ar, vec[i].ad, vec[i].bv, vec[i].br, vec[i].bd);
            step();
            chk($sformatf("v%0d we", i), 32'(RF_WRITE_ENABLE), 32'(vec[i].we));
            chk($sformatf("v%0d wreg", i), 32'(RF_WRITE_REG), 32'(vec[i].wreg));
            chk($sformatf("v%0d wdata", i), RF_WRITE_DATA, vec[i].wdata);
            chk($sformatf("v%0d a_rdy", i), 32'(A_READY), 32'(vec[i].a_rdy));
            chk($sformatf("v%0d b_rdy", i), 32'(B_READY), 32'(vec[i].b_rdy));
            chk($sformatf("v%0d pend", i), 32'(B_PENDING), 32'(vec[i].pend));
            chk($sformatf("v%0d preg", i), 32'(B_PENDING_REG), 32'(vec[i].preg));
        end

        // Starvation: B buffered while A streams; four A wins, then one forced B slot.
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'(10 + i), 32'(100 + i), i == 0, 9, 32'h99);
            step();
            chk($sformatf("starve%0d we", i), 32'(RF_WRITE_ENABLE), 32'd1);
            chk($sformatf("starve%0d wreg", i), 32'(RF_WRITE_REG), 32'(10 + i));
            chk($sformatf("starve%0d pend", i), 32'(B_PENDING), 32'd1);
            chk($sformatf("starve%0d a_rdy", i), 32'(A_READY), i < 4 ? 32'd1 : 32'd0);
        end
        drive(1, 15, 32'd105, 0, 0, 0);
        step();
        chk("forced wreg", 32'(RF_WRITE_REG), 32'd9);
        chk("forced wdata", RF_WRITE_DATA, 32'h99);
        chk("forced pend", 32'(B_PENDING), 32'd0);
        chk("forced a_rdy", 32'(A_READY), 32'd1);
        step();
        chk("resume wreg", 32'(RF_WRITE_REG), 32'd15);
        chk("resume wdata", RF_WRITE_DATA, 32'd105);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("post-starve we", 32'(RF_WRITE_ENABLE), 32'd0);

        // Reset with B buffered and wait_cnt at 2 discards the result.
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(20 + i), 32'(200 + i), i == 0, 11, 32'hBB);
            step();
        end
        chk("pre-rst pend", 32'(B_PENDING), 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk_idle("midrst");
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post-rst%0d we", i), 32'(RF_WRITE_ENABLE), 32'd0);
            chk($sformatf("post-rst%0d pend", i), 32'(B_PENDING), 32'd0);
        end

`ifdef REGFILE_WB_ARB_STATS_EN
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'(20 + i), 32'(i), i == 0, 21, 32'h21);
            step();
        end
        drive(1, 25, 32'd5, 0, 0, 0);
        step();
        step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("stats a_writes", A_WRITES, 32'd6);
        chk("stats b_writes", B_WRITES, 32'd1);
        chk("stats force_cnt", 32'(FORCE_CNT), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
